// File: rtl/dpmem_arbiter_if.sv
// One request/acknowledge channel of dpmem_arbiter: master drives the request,
// slave (the arbiter) returns ack, rvalid and rdata.
interface dpmem_arbiter_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 10
);
   logic                  req;
   logic                  we;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  ack;
   logic                  rvalid;
   logic [DATA_WIDTH-1:0] rdata;

   modport master (output req, we, addr, wdata, input  ack, rvalid, rdata);
   modport slave  (input  req, we, addr, wdata, output ack, rvalid, rdata);
endinterface

// File: rtl/dpmem_arbiter.sv
// Dual-channel true dual-port RAM with same-address round-robin arbitration and
// 1- or 2-cycle read return. `define COLLISION_CNT_EN adds a saturating conflict counter.
module dpmem_arbiter #(
   parameter int DATA_WIDTH   = 16,
   parameter int ADDR_WIDTH   = 10,
   parameter int READ_LATENCY = 1
) (
   input  logic           clk,
   input  logic           reset,
   dpmem_arbiter_if.slave a,
   dpmem_arbiter_if.slave b
`ifdef COLLISION_CNT_EN
   ,
   output logic [15:0]    collision_count
`endif
);
   typedef enum logic {PRI_A, PRI_B} pri_e;

   pri_e pri_q, pri_d;
   logic conflict, a_ack, b_ack, a_rd, b_rd;

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   logic                  a_v1_q, b_v1_q;
   logic [DATA_WIDTH-1:0] a_d1_q, b_d1_q;

   // A conflict is any same-address pair involving a write; the holder wins and yields.
   always_comb begin
      conflict = a.req && b.req && (a.addr == b.addr) && (a.we || b.we);
      a_ack    = a.req && (!conflict || (pri_q == PRI_A));
      b_ack    = b.req && (!conflict || (pri_q == PRI_B));
      pri_d    = pri_q;
      if (conflict) begin
         pri_d = (pri_q == PRI_A) ? PRI_B : PRI_A;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pri_q <= PRI_A;
      end else begin
         pri_q <= pri_d;
      end
   end

   assign a.ack = a_ack;
   assign b.ack = b_ack;
   assign a_rd  = a_ack && !a.we;
   assign b_rd  = b_ack && !b.we;

   // Storage is deliberately not reset so contents survive a reset pulse.
   always_ff @(posedge clk) begin
      if (a_ack && a.we) mem[a.addr] <= a.wdata;
      if (b_ack && b.we) mem[b.addr] <= b.wdata;
   end

   // d1 only loads on a read, so it also serves as the held rdata at latency 1.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_v1_q <= 1'b0;
         b_v1_q <= 1'b0;
         a_d1_q <= '0;
         b_d1_q <= '0;
      end else begin
         a_v1_q <= a_rd;
         b_v1_q <= b_rd;
         if (a_rd) a_d1_q <= mem[a.addr];
         if (b_rd) b_d1_q <= mem[b.addr];
      end
   end

   if (READ_LATENCY == 2) begin : g_lat2
      logic                  a_v2_q, b_v2_q;
      logic [DATA_WIDTH-1:0] a_d2_q, b_d2_q;

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            a_v2_q <= 1'b0;
            b_v2_q <= 1'b0;
            a_d2_q <= '0;
            b_d2_q <= '0;
         end else begin
            a_v2_q <= a_v1_q;
            b_v2_q <= b_v1_q;
            if (a_v1_q) a_d2_q <= a_d1_q;
            if (b_v1_q) b_d2_q <= b_d1_q;
         end
      end

      assign a.rvalid = a_v2_q;
      assign a.rdata  = a_d2_q;
      assign b.rvalid = b_v2_q;
      assign b.rdata  = b_d2_q;
   end else begin : g_lat1
      assign a.rvalid = a_v1_q;
      assign a.rdata  = a_d1_q;
      assign b.rvalid = b_v1_q;
      assign b.rdata  = b_d1_q;
   end

`ifdef COLLISION_CNT_EN
   logic [15:0] cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (conflict && (cnt_q != '1)) begin
         cnt_q <= cnt_q + 16'd1;
      end
   end

   assign collision_count = cnt_q;
`endif
endmodule

// File: tb/tb_dpmem_arbiter.sv
// Drives one stimulus stream into a latency-1 and a latency-2 instance and checks
// both every cycle against a transaction-level model, plus literal spot checks.
module tb_dpmem_arbiter;
   logic clk, reset;

   dpmem_arbiter_if #(.DATA_WIDTH(16), .ADDR_WIDTH(10)) a1 ();
   dpmem_arbiter_if #(.DATA_WIDTH(16), .ADDR_WIDTH(10)) b1 ();
   dpmem_arbiter_if #(.DATA_WIDTH(16), .ADDR_WIDTH(10)) a2 ();
   dpmem_arbiter_if #(.DATA_WIDTH(16), .ADDR_WIDTH(10)) b2 ();

`ifdef COLLISION_CNT_EN
   logic [15:0] cc1, cc2;
`endif

   dpmem_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .READ_LATENCY(1)) dut1 (
      .clk(clk), .reset(reset), .a(a1), .b(b1)
`ifdef COLLISION_CNT_EN
      , .collision_count(cc1)
`endif
   );

   dpmem_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .READ_LATENCY(2)) dut2 (
      .clk(clk), .reset(reset), .a(a2), .b(b2)
`ifdef COLLISION_CNT_EN
      , .collision_count(cc2)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int nvec = 0;
   int nerr = 0;

   task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
      end
   endtask

   // Model: expected rvalid/rdata per instance (k: latency k+1), channel, cycle.
   bit          ev [2][2][1024];
   logic [15:0] ed [2][2][1024];
   logic [15:0] last [2][2];
   logic [15:0] mm [1024];
   bit          pri;
   int          mcnt;
   int          cyc = 0;
   logic        m_conf, m_ea, m_eb;

   always @(negedge clk) begin
      cyc++;
      if (reset) begin
         pri  = 1'b0;
         mcnt = 0;
         for (int k = 0; k < 2; k++)
            for (int ch = 0; ch < 2; ch++) begin
               last[k][ch] = 16'h0000;
               for (int c = cyc; c < 1024; c++) ev[k][ch][c] = 1'b0;
            end
      end
      for (int k = 0; k < 2; k++)
         for (int ch = 0; ch < 2; ch++)
            if (ev[k][ch][cyc]) last[k][ch] = ed[k][ch][cyc];

      chk("L1 a_rvalid", 16'(a1.rvalid), 16'(ev[0][0][cyc]));
      chk("L1 a_rdata",  a1.rdata,       last[0][0]);
      chk("L1 b_rvalid", 16'(b1.rvalid), 16'(ev[0][1][cyc]));
      chk("L1 b_rdata",  b1.rdata,       last[0][1]);
      chk("L2 a_rvalid", 16'(a2.rvalid), 16'(ev[1][0][cyc]));
      chk("L2 a_rdata",  a2.rdata,       last[1][0]);
      chk("L2 b_rvalid", 16'(b2.rvalid), 16'(ev[1][1][cyc]));
      chk("L2 b_rdata",  b2.rdata,       last[1][1]);
`ifdef COLLISION_CNT_EN
      chk("L1 collision_count", cc1, 16'(mcnt));
      chk("L2 collision_count", cc2, 16'(mcnt));
`endif

      m_conf = a1.req && b1.req && (a1.addr == b1.addr) && (a1.we || b1.we);
      m_ea   = a1.req && (!m_conf || !pri);
      m_eb   = b1.req && (!m_conf || pri);
      chk("L1 a_ack", 16'(a1.ack), 16'(m_ea));
      chk("L1 b_ack", 16'(b1.ack), 16'(m_eb));
      chk("L2 a_ack", 16'(a2.ack), 16'(m_ea));
      chk("L2 b_ack", 16'(b2.ack), 16'(m_eb));

      if (!reset && cyc < 1000) begin
         for (int k = 0; k < 2; k++) begin
            if (m_ea && !a1.we) begin
               ev[k][0][cyc+k+1] = 1'b1;
               ed[k][0][cyc+k+1] = mm[a1.addr];
            end
            if (m_eb && !b1.we) begin
               ev[k][1][cyc+k+1] = 1'b1;
               ed[k][1][cyc+k+1] = mm[b1.addr];
            end
         end
         if (m_ea && a1.we) mm[a1.addr] = a1.wdata;
         if (m_eb && b1.we) mm[b1.addr] = b1.wdata;
         if (m_conf) begin
            pri = m_ea ? 1'b1 : 1'b0;
            if (mcnt < 65535) mcnt++;
         end
      end
   end

   task automatic set(input logic ar, input logic aw, input logic [9:0] aa, input logic [15:0] ad,
                      input logic br, input logic bw, input logic [9:0] ba, input logic [15:0] bd);
      a1.req = ar; a1.we = aw; a1.addr = aa; a1.wdata = ad;
      a2.req = ar; a2.we = aw; a2.addr = aa; a2.wdata = ad;
      b1.req = br; b1.we = bw; b1.addr = ba; b1.wdata = bd;
      b2.req = br; b2.we = bw; b2.addr = ba; b2.wdata = bd;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      set(0, 0, 10'd0, 16'h0, 0, 0, 10'd0, 16'h0);
      repeat (n) step();
   endtask

   task automatic do_reset(input int n);
      idle(0);
      reset = 1'b1;
      repeat (n) step();
      reset = 1'b0;
      step();
   endtask

   initial begin
      int ai, bi;
      reset = 1'b1;
      idle(3);
      reset = 1'b0;
      step();

      // parallel writes, then parallel reads
      set(1, 1, 10'h000, 16'h000F, 1, 1, 10'h002, 16'h3000); #1;
      chk("par a_ack", 16'(a1.ack), 16'h1);
      chk("par b_ack", 16'(b1.ack), 16'h1);
      step();
      set(1, 1, 10'h001, 16'h00F0, 1, 1, 10'h003, 16'h0C00); step();
      set(1, 0, 10'h000, 16'h0000, 1, 0, 10'h002, 16'h0000); step();
      idle(3);
      chk("par L1 a_rdata", a1.rdata, 16'h000F);
      chk("par L2 b_rdata", b2.rdata, 16'h3000);

      // shared same-address read
      set(1, 0, 10'h001, 16'h0, 1, 0, 10'h001, 16'h0); #1;
      chk("shr b_ack", 16'(b1.ack), 16'h1);
      step();
      idle(3);
      chk("shr L1 a_rdata", a1.rdata, 16'h00F0);
      chk("shr L2 b_rdata", b2.rdata, 16'h00F0);

      // same-address write conflict, A then B, A's follow-up read stalls once
      do_reset(2);
      set(1, 1, 10'h005, 16'h1111, 1, 1, 10'h005, 16'h2222); #1;
      chk("cf1 a_ack", 16'(a1.ack), 16'h1);
      chk("cf1 b_ack", 16'(b1.ack), 16'h0);
      step();
      set(1, 0, 10'h005, 16'h0, 1, 1, 10'h005, 16'h2222); #1;
      chk("cf2 a_ack", 16'(a1.ack), 16'h0);
      chk("cf2 b_ack", 16'(b1.ack), 16'h1);
      step();
      set(1, 0, 10'h005, 16'h0, 0, 0, 10'h000, 16'h0); #1;
      chk("cf3 a_ack", 16'(a1.ack), 16'h1);
      step();
      idle(3);
      chk("cf L1 a_rdata", a1.rdata, 16'h2222);
      chk("cf L2 a_rdata", a2.rdata, 16'h2222);

      // fairness: four conflicting cycles on 0x007 alternate A,B,A,B
      do_reset(1);
      ai = 0; bi = 0;
      for (int i = 0; i < 4; i++) begin
         set(1, 1, 10'h007, 16'hA000 + 16'(ai), 1, 1, 10'h007, 16'hB000 + 16'(bi)); #1;
         chk("fair a_ack", 16'(a1.ack), (i % 2 == 0) ? 16'h1 : 16'h0);
         chk("fair b_ack", 16'(b1.ack), (i % 2 == 0) ? 16'h0 : 16'h1);
         if (i % 2 == 0) ai++; else bi++;
         step();
      end
      set(1, 0, 10'h007, 16'h0, 0, 0, 10'h000, 16'h0); step();
      idle(3);
      chk("fair L1 a_rdata", a1.rdata, 16'hB001);
`ifdef COLLISION_CNT_EN
      chk("fair collision_count", cc1, 16'd4);
`endif

      // pipelined reads of 0,1,2 on A
      set(1, 0, 10'h000, 16'h0, 0, 0, 10'h000, 16'h0); step();
      set(1, 0, 10'h001, 16'h0, 0, 0, 10'h000, 16'h0); step();
      set(1, 0, 10'h002, 16'h0, 0, 0, 10'h000, 16'h0);
      chk("pipe L2 rv0", 16'(a2.rvalid), 16'h1);
      chk("pipe L2 rd0", a2.rdata, 16'h000F);
      chk("pipe L1 rd1", a1.rdata, 16'h00F0);
      step();
      idle(0);
      chk("pipe L2 rd1", a2.rdata, 16'h00F0);
      step();
      chk("pipe L2 rd2", a2.rdata, 16'h3000);
      chk("pipe L2 rv2", 16'(a2.rvalid), 16'h1);
      step();
      chk("pipe L2 rv end", 16'(a2.rvalid), 16'h0);
      chk("pipe L2 hold", a2.rdata, 16'h3000);
      idle(2);

      // reset lands one cycle after a read of 0x003 is accepted
      set(1, 0, 10'h003, 16'h0, 0, 0, 10'h000, 16'h0); step();
      do_reset(2);
      idle(2);
      chk("rst L1 a_rdata", a1.rdata, 16'h0000);
      chk("rst L2 a_rdata", a2.rdata, 16'h0000);
      set(1, 0, 10'h003, 16'h0, 0, 0, 10'h000, 16'h0); step();
      idle(3);
      chk("rst retain L2", a2.rdata, 16'h0C00);

      // top address, and cross-channel read right after a write
      set(1, 1, 10'h3FF, 16'hABCD, 1, 1, 10'h010, 16'h5555); step();
      set(1, 0, 10'h3FF, 16'h0, 0, 0, 10'h000, 16'h0); step();
      set(0, 0, 10'h000, 16'h0, 1, 0, 10'h010, 16'h0); step();
      set(1, 1, 10'h011, 16'h7777, 0, 0, 10'h000, 16'h0); step();
      set(0, 0, 10'h000, 16'h0, 1, 0, 10'h011, 16'h0); step();
      idle(3);
      chk("top L1 a_rdata", a1.rdata, 16'hABCD);
      chk("raw L2 b_rdata", b2.rdata, 16'h7777);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
